// File: rtl/pdot_eat_controller.sv
// pdot_eat_controller: eats one pac-dot per frame, tracks score, arbitrates breakable-wall
// placement against a per-level budget and flags level completion.
module pdot_eat_controller #(
  parameter int DOT_POINTS  = 10,
  parameter int BWALL_COUNT = 3,
  parameter int SCORE_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start_of_frame,
  input  logic               i_pacman_dr,
  input  logic               i_pdots_dr,
  input  logic               i_pdots_exist,
  input  logic               i_place_bwall_req,
  input  logic [6:0]         i_target_tile_x,
  input  logic [6:0]         i_target_tile_y,
  input  logic               i_is_bwall_valid,
  output logic               o_remove_cur_pdot,
  output logic [1:0][6:0]    o_generate_bwall_at,
  output logic [SCORE_W-1:0] o_score,
  output logic [3:0]         o_bwalls_left,
  output logic               o_bwall_placed,
  output logic               o_bwall_rejected,
  output logic               o_level_complete
);
  typedef enum logic [1:0] {E_WAIT, E_ARMED, E_DONE} eat_t;
  typedef enum logic {W_IDLE, W_DRIVE} wall_t;

  eat_t         r_eat, w_eat_nx;
  wall_t        r_wall, w_wall_nx;
  logic         w_eat, w_latch, w_place_ok, w_reject, w_level;
  logic [6:0]   r_tx, r_ty;
  logic         r_prev;
  logic [SCORE_W:0] w_sum;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_eat  <= E_WAIT;
      r_wall <= W_IDLE;
    end else begin
      r_eat  <= w_eat_nx;
      r_wall <= w_wall_nx;
    end
  end

  always_comb begin
    w_eat_nx   = r_eat;
    w_wall_nx  = r_wall;
    w_eat      = 1'b0;
    w_latch    = 1'b0;
    w_place_ok = 1'b0;
    w_reject   = 1'b0;
    case (r_eat)
      E_WAIT:  w_eat_nx = i_start_of_frame ? E_ARMED : E_WAIT;
      E_ARMED: begin
        w_eat    = i_pacman_dr & i_pdots_dr;
        w_eat_nx = w_eat ? E_DONE : E_ARMED;
      end
      E_DONE:  w_eat_nx = i_start_of_frame ? E_ARMED : E_DONE;
      default: w_eat_nx = E_WAIT;
    endcase
    case (r_wall)
      W_IDLE: begin
        w_latch   = i_place_bwall_req & (o_bwalls_left != 4'd0);
        w_reject  = i_place_bwall_req & (o_bwalls_left == 4'd0);
        w_wall_nx = w_latch ? W_DRIVE : W_IDLE;
      end
      default: begin
        w_place_ok = i_is_bwall_valid;
        w_reject   = ~i_is_bwall_valid;
        w_wall_nx  = W_IDLE;
      end
    endcase
  end

  assign w_level = r_prev & ~i_pdots_exist;
  assign w_sum   = {1'b0, o_score} + (SCORE_W+1)'(DOT_POINTS);
  // Tile {0,0} is a border wall the generator never accepts, so it doubles as "no request".
  assign o_generate_bwall_at = (r_wall == W_DRIVE) ? {r_ty, r_tx} : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_remove_cur_pdot <= 1'b0;
      o_score           <= '0;
      o_bwalls_left     <= 4'(BWALL_COUNT);
      o_bwall_placed    <= 1'b0;
      o_bwall_rejected  <= 1'b0;
      o_level_complete  <= 1'b0;
      r_tx              <= '0;
      r_ty              <= '0;
      r_prev            <= 1'b0;
    end else begin
      o_remove_cur_pdot <= w_eat;
      if (w_eat) o_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
      if (w_latch) begin
        r_tx <= i_target_tile_x;
        r_ty <= i_target_tile_y;
      end
      o_bwall_placed   <= w_place_ok;
      o_bwall_rejected <= w_reject;
      o_level_complete <= w_level;
      r_prev           <= i_pdots_exist;
      o_bwalls_left    <= w_level ? 4'(BWALL_COUNT) : w_place_ok ? o_bwalls_left - 4'd1 : o_bwalls_left;
    end
  end
endmodule

// File: tb/tb_pdot_eat_controller.sv
// tb_pdot_eat_controller: table-driven vectors with a scoreboard queue, plus hand-written
// saturation and reset-during-drive sequences.
module tb_pdot_eat_controller;
  logic i_clk = 1'b0, i_reset = 1'b1;
  logic i_start_of_frame = 0, i_pacman_dr = 0, i_pdots_dr = 0, i_pdots_exist = 1;
  logic i_place_bwall_req = 0, i_is_bwall_valid = 0;
  logic [6:0] i_target_tile_x = 0, i_target_tile_y = 0;
  logic o_remove_cur_pdot, o_bwall_placed, o_bwall_rejected, o_level_complete;
  logic [1:0][6:0] o_generate_bwall_at;
  logic [15:0] o_score;
  logic [3:0] o_bwalls_left;
  int n_cmp = 0, n_bad = 0;

  pdot_eat_controller dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start_of_frame(i_start_of_frame),
    .i_pacman_dr(i_pacman_dr), .i_pdots_dr(i_pdots_dr), .i_pdots_exist(i_pdots_exist),
    .i_place_bwall_req(i_place_bwall_req), .i_target_tile_x(i_target_tile_x),
    .i_target_tile_y(i_target_tile_y), .i_is_bwall_valid(i_is_bwall_valid),
    .o_remove_cur_pdot(o_remove_cur_pdot), .o_generate_bwall_at(o_generate_bwall_at),
    .o_score(o_score), .o_bwalls_left(o_bwalls_left), .o_bwall_placed(o_bwall_placed),
    .o_bwall_rejected(o_bwall_rejected), .o_level_complete(o_level_complete)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic sof, pac, pd, ex, req;
    logic [6:0] x, y;
    logic vld, rm;
    logic [6:0] bx, by;
    logic [15:0] sc;
    logic [3:0] lft;
    logic pl, rj, lv;
  } vec_t;

  vec_t tbl[25];
  vec_t sb[$];

  function automatic vec_t mk(input logic sof, pac, pd, ex, req, input int x, y,
                              input logic vld, rm, input int bx, by, sc, lft,
                              input logic pl, rj, lv);
    vec_t v;
    v.sof = sof; v.pac = pac; v.pd = pd; v.ex = ex; v.req = req;
    v.x = 7'(x); v.y = 7'(y); v.vld = vld; v.rm = rm;
    v.bx = 7'(bx); v.by = 7'(by); v.sc = 16'(sc); v.lft = 4'(lft);
    v.pl = pl; v.rj = rj; v.lv = lv;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    i_start_of_frame = v.sof; i_pacman_dr = v.pac; i_pdots_dr = v.pd;
    i_pdots_exist = v.ex; i_place_bwall_req = v.req;
    i_target_tile_x = v.x; i_target_tile_y = v.y; i_is_bwall_valid = v.vld;
    sb.push_back(v);
    @(posedge i_clk);
    #1;
    e = sb.pop_front();
    chk("remove", int'(o_remove_cur_pdot), int'(e.rm));
    chk("bus_x", int'(o_generate_bwall_at[0]), int'(e.bx));
    chk("bus_y", int'(o_generate_bwall_at[1]), int'(e.by));
    chk("score", int'(o_score), int'(e.sc));
    chk("bwalls_left", int'(o_bwalls_left), int'(e.lft));
    chk("placed", int'(o_bwall_placed), int'(e.pl));
    chk("rejected", int'(o_bwall_rejected), int'(e.rj));
    chk("level", int'(o_level_complete), int'(e.lv));
  endtask

  initial begin
    int m;
    //               sof pac pd ex req x  y vld  rm bx by sc  lft pl rj lv
    tbl[0]  = mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0,  0, 3, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0,  0, 3, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 10, 3, 0, 0, 0);
    tbl[3]  = mk(0, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 10, 3, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 10, 3, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 10, 3, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 20, 3, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 20, 3, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 1, 1, 1, 1, 0,  0, 1, 1, 20, 3, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 20, 2, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 20, 2, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 1, 5, 9, 0,  0, 5, 9, 20, 2, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 20, 2, 0, 1, 0);
    tbl[13] = mk(0, 0, 0, 1, 1, 2, 3, 0,  0, 2, 3, 20, 2, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 1, 1, 7, 7, 1,  0, 0, 0, 20, 1, 1, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 1, 4, 4, 0,  0, 4, 4, 20, 1, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 20, 0, 1, 0, 0);
    tbl[17] = mk(0, 0, 0, 1, 1, 6, 6, 1,  0, 0, 0, 20, 0, 0, 1, 0);
    tbl[18] = mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 20, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 20, 3, 0, 0, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 20, 3, 0, 0, 0);
    tbl[21] = mk(1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 20, 3, 0, 0, 0);
    tbl[22] = mk(0, 0, 0, 1, 1, 3, 3, 0,  0, 3, 3, 20, 3, 0, 0, 0);
    tbl[23] = mk(0, 1, 1, 1, 0, 0, 0, 1,  1, 0, 0, 30, 2, 1, 0, 0);
    tbl[24] = mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 30, 2, 0, 0, 0);

    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_remove", int'(o_remove_cur_pdot), 0);
    chk("reset_bus", int'(o_generate_bwall_at), 0);
    chk("reset_score", int'(o_score), 0);
    chk("reset_left", int'(o_bwalls_left), 3);
    chk("reset_pulses", int'({o_bwall_placed, o_bwall_rejected, o_level_complete}), 0);
    i_reset = 1'b0;

    for (int i = 0; i < 25; i++) apply(tbl[i]);

    // Saturation: eat one dot per frame until the score pins at all-ones, then once more.
    m = 30;
    while (m < 65535) begin
      apply(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, m, 2, 0, 0, 0));
      m = (m + 10 > 65535) ? 65535 : m + 10;
      apply(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, m, 2, 0, 0, 0));
    end
    apply(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 65535, 2, 0, 0, 0));
    apply(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 65535, 2, 0, 0, 0));

    // Reset arrives mid-cycle while the placement tile is being driven.
    apply(mk(0, 0, 0, 1, 1, 9, 9, 0, 0, 9, 9, 65535, 2, 0, 0, 0));
    i_place_bwall_req = 1'b0;
    i_is_bwall_valid  = 1'b1;
    #2;
    i_reset = 1'b1;
    #1;
    chk("rst_drive_bus", int'(o_generate_bwall_at), 0);
    chk("rst_drive_score", int'(o_score), 0);
    chk("rst_drive_left", int'(o_bwalls_left), 3);
    @(posedge i_clk);
    #1;
    chk("rst_drive_placed", int'(o_bwall_placed), 0);
    chk("rst_drive_remove", int'(o_remove_cur_pdot), 0);
    i_reset = 1'b0;
    apply(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
